// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } snap_cls_e;

    // Active-low one-hot column drive, indexed by column number.
    localparam logic [3:0][3:0] COL_DRV = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous, pulled-up row inputs.
module keypad_sync2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_dec.sv
// 4x4 active-low keypad scanner: column scan, full-matrix snapshot, press/release
// debounce and a nibble shift buffer of accepted key codes.
module keypad_scan_dec
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        key_clr,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] key_buf
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    logic [SLOT_W-1:0] slot_q;
    logic [1:0]        col_q;
    logic [15:0]       snap_q;
    logic [15:0]       snap_eval;
    logic [3:0]        rows_sync;
    logic [3:0]        keys_dn;
    logic              slot_end;
    logic              scan_done;

    state_e            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic [3:0]        key_code_q;
    logic              key_valid_q;
    logic [31:0]       key_buf_q;

    snap_cls_e         cls;
    logic [4:0]        ones;
    logic [3:0]        idx;
    logic [3:0]        code;

    keypad_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_in),
        .q_o   (rows_sync)
    );

    assign keys_dn   = ~rows_sync;
    assign slot_end  = (slot_q == SLOT_W'(SCAN_DIV - 1));
    assign scan_done = slot_end && (col_q == 2'd3);
    assign col_out   = COL_DRV[col_q];

    // Column 3 is sampled on the same edge that evaluates the scan, so fold it in here.
    always_comb begin
        snap_eval        = snap_q;
        snap_eval[15:12] = keys_dn;
    end

    // Snapshot is column-major (bit = col*4+row); key codes are row*4+col.
    always_comb begin
        ones = 5'd0;
        idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_eval[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
        if (ones == 5'd0)      cls = NONE;
        else if (ones == 5'd1) cls = SINGLE;
        else                   cls = MULTI;
        code = {idx[1:0], idx[3:2]};
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (cls == SINGLE) begin
                        cand_d  = code;
                        cnt_d   = CNT_W'(1);
                        state_d = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (cls == SINGLE && code == cand_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (cls == NONE) begin
                        cnt_d   = CNT_W'(1);
                        state_d = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (cls == NONE) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) state_d = IDLE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            col_q       <= 2'd0;
            snap_q      <= 16'h0;
            state_q     <= IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_buf_q   <= 32'h0;
        end else begin
            slot_q <= slot_end ? '0 : slot_q + SLOT_W'(1);
            if (slot_end) col_q <= col_q + 2'd1;
            if (scan_done)     snap_q <= 16'h0;
            else if (slot_end) snap_q[{col_q, 2'b00} +: 4] <= keys_dn;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= accept;
            if (accept) key_code_q <= cand_q;
            // A clear on the acceptance edge still keeps the newly accepted key.
            if (accept && key_clr) key_buf_q <= {28'h0, cand_q};
            else if (accept)       key_buf_q <= {key_buf_q[27:0], cand_q};
            else if (key_clr)      key_buf_q <= 32'h0;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == PRESSED) || (state_q == DEB_REL);
    assign key_buf   = key_buf_q;

endmodule

// File: tb/tb_keypad_scan_dec.sv
// Directed bench for keypad_scan_dec with a behavioural 4x4 key matrix.
module tb_keypad_scan_dec;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_clr;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] key_buf;
    logic [15:0] keys;

    int vectors     = 0;
    int miscompares = 0;
    int kv_cnt      = 0;

    keypad_scan_dec #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_clr   (key_clr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_buf   (key_buf)
    );

    always #5 clk = ~clk;

    // Key at bit row*4+col pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    always @(negedge clk) if (key_valid === 1'b1) kv_cnt++;

    // Returns #1 after the edge on which the column-3 slot wraps back to column 0.
    task automatic next_scan();
        logic [3:0] prev;
        bit done;
        done = 1'b0;
        prev = col_out;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (prev == 4'b0111 && col_out == 4'b1110) done = 1'b1;
            prev = col_out;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL scan_boundary: got col_out %b, no wrap within 40 clk", col_out);
        end
    endtask

    task automatic pulse_clr();
        key_clr = 1'b1;
        @(posedge clk); #1;
        key_clr = 1'b0;
        vectors++;
        if (key_buf !== 32'h0) begin
            miscompares++;
            $display("FAIL clr_buf: got %h expected %h", key_buf, 32'h0);
        end
    endtask

    task automatic press_release(input logic [3:0] c);
        keys = 16'h1 << c;
        repeat (DEB) next_scan();
        vectors++;
        if (key_valid !== 1'b1 || key_code !== c) begin
            miscompares++;
            $display("FAIL press_%0d: got valid %b code %h expected 1 %h", c, key_valid, key_code, c);
        end
        keys = 16'h0;
        repeat (DEB) next_scan();
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst_n = 1'b0; key_clr = 1'b0; keys = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (col_out !== 4'b1110) begin miscompares++; $display("FAIL rst_col: got %b expected 1110", col_out); end
        vectors++; if (key_code !== 4'h0) begin miscompares++; $display("FAIL rst_code: got %h expected 0", key_code); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", key_valid); end
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL rst_held: got %b expected 0", key_held); end
        vectors++; if (key_buf !== 32'h0) begin miscompares++; $display("FAIL rst_buf: got %h expected 0", key_buf); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            vectors++;
            if (col_out !== exp_col) begin
                miscompares++;
                $display("FAIL col_walk[%0d]: got %b expected %b", k, col_out, exp_col);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clean_press();
        int k0;
        k0 = kv_cnt;
        keys = 16'h1 << 9;
        next_scan(); next_scan();
        vectors++; if (kv_cnt != k0 || key_held !== 1'b0) begin miscompares++; $display("FAIL press_early: got pulses %0d held %b expected 0 0", kv_cnt - k0, key_held); end
        next_scan();
        vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL press_valid: got %b expected 1", key_valid); end
        vectors++; if (key_code !== 4'h9) begin miscompares++; $display("FAIL press_code: got %h expected 9", key_code); end
        vectors++; if (key_buf !== 32'h0000_0009) begin miscompares++; $display("FAIL press_buf: got %h expected 00000009", key_buf); end
        vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL press_held: got %b expected 1", key_held); end
        @(posedge clk); #1;
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL press_pulse_width: got %b expected 0", key_valid); end
        next_scan(); next_scan();
        vectors++; if (kv_cnt - k0 != 1) begin miscompares++; $display("FAIL press_pulse_count: got %0d expected 1", kv_cnt - k0); end
        keys = 16'h0;
        repeat (DEB) next_scan();
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL press_release_held: got %b expected 0", key_held); end
        vectors++; if (key_code !== 4'h9) begin miscompares++; $display("FAIL code_hold: got %h expected 9", key_code); end
    endtask

    task automatic test_bounce();
        int k0;
        k0 = kv_cnt;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (16'h1 << 5) : 16'h0;
            next_scan();
            vectors++;
            if (key_held !== 1'b0) begin miscompares++; $display("FAIL bounce_held[%0d]: got %b expected 0", i, key_held); end
        end
        keys = 16'h0;
        next_scan();
        vectors++; if (kv_cnt != k0) begin miscompares++; $display("FAIL bounce_pulses: got %0d expected 0", kv_cnt - k0); end
        vectors++; if (key_buf !== 32'h0000_0009) begin miscompares++; $display("FAIL bounce_buf: got %h expected 00000009", key_buf); end
    endtask

    task automatic test_multi_key();
        int k0;
        pulse_clr();
        next_scan();
        k0 = kv_cnt;
        keys = (16'h1 << 1) | (16'h1 << 6);
        for (int i = 0; i < 10; i++) begin
            next_scan();
            vectors++;
            if (key_held !== 1'b0) begin miscompares++; $display("FAIL multi_held[%0d]: got %b expected 0", i, key_held); end
        end
        keys = 16'h0;
        next_scan(); next_scan();
        vectors++; if (kv_cnt != k0) begin miscompares++; $display("FAIL multi_pulses: got %0d expected 0", kv_cnt - k0); end
        keys = 16'h1 << 15;
        repeat (DEB) next_scan();
        vectors++; if (key_valid !== 1'b1 || key_code !== 4'hF) begin miscompares++; $display("FAIL multi_then_F: got valid %b code %h expected 1 F", key_valid, key_code); end
        vectors++; if (key_buf !== 32'h0000_000F) begin miscompares++; $display("FAIL multi_buf: got %h expected 0000000F", key_buf); end
        @(posedge clk); #1;
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL multi_pulse_width: got %b expected 0", key_valid); end
    endtask

    task automatic test_release_debounce();
        int k0;
        k0 = kv_cnt;
        keys = 16'h0;
        next_scan();
        vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL rel_held_1: got %b expected 1", key_held); end
        next_scan();
        vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL rel_held_2: got %b expected 1", key_held); end
        keys = 16'h1 << 15;
        next_scan();
        vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL rel_rebound: got %b expected 1", key_held); end
        keys = 16'h0;
        next_scan(); next_scan();
        vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL rel_held_pre: got %b expected 1", key_held); end
        next_scan();
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL rel_done: got %b expected 0", key_held); end
        vectors++; if (kv_cnt != k0) begin miscompares++; $display("FAIL rel_pulses: got %0d expected 0", kv_cnt - k0); end
        vectors++; if (key_code !== 4'hF) begin miscompares++; $display("FAIL rel_code: got %h expected F", key_code); end
    endtask

    task automatic test_clr_coincident();
        bit found;
        pulse_clr();
        next_scan();
        press_release(4'h1);
        press_release(4'h2);
        vectors++; if (key_buf !== 32'h0000_0012) begin miscompares++; $display("FAIL clr_setup_buf: got %h expected 00000012", key_buf); end
        keys = 16'h1 << 3;
        next_scan(); next_scan();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (col_out == 4'b0111) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL clr_col3_wait: got col_out %b expected 0111", col_out); end
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1 key_clr = 1'b1;
        @(posedge clk); #1;
        key_clr = 1'b0;
        vectors++; if (key_valid !== 1'b1 || key_code !== 4'h3) begin miscompares++; $display("FAIL clr_accept: got valid %b code %h expected 1 3", key_valid, key_code); end
        vectors++; if (key_buf !== 32'h0000_0003) begin miscompares++; $display("FAIL clr_coincident_buf: got %h expected 00000003", key_buf); end
        keys = 16'h0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_release_debounce();
        test_clr_coincident();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
